// File: rtl/count_tick_ctrl_pkg.sv
// Shared constants and FSM encoding for the LED counter rate/step controller.
// Defaults are derived from the board clock so a clock change only touches CLK_HZ.
package count_tick_ctrl_pkg;

   localparam int CLK_HZ           = 134_000_000;
   localparam int DEFAULT_PRESCALE = 1 << $clog2(CLK_HZ);
   localparam int DEFAULT_DEBOUNCE = CLK_HZ / 100;

   typedef enum logic {
      ST_PAUSED  = 1'b0,
      ST_RUNNING = 1'b1
   } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-count debouncer and a
// registered rising-edge detector that yields one press pulse per debounced press.
module btn_debounce
   import count_tick_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_a;
   logic          sync_b;
   logic          level_q;
   logic [CW-1:0] cnt;

   // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample; any match restarts the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a  <= 1'b0;
         sync_b  <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         press   <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_a  <= btn_raw;
         sync_b  <= sync_a;
         level_q <= level;
         press   <= level & ~level_q;
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/count_tick_ctrl.sv
// Tick generator for the LED counter: free-running prescaled ticks while RUNNING,
// one tick per step press while PAUSED, run button toggles between the two.
module count_tick_ctrl
   import count_tick_ctrl_pkg::*;
#(
   parameter int PRESCALE        = DEFAULT_PRESCALE,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_run,
   input  logic btn_step,
   output logic tick,
   output logic running
);

   localparam int            PW         = $clog2(PRESCALE);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   state_t        state;
   state_t        state_next;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_next;
   logic          tick_next;
   logic          run_press;
   logic          step_press;
   logic          unused_run_level;
   logic          unused_step_level;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_run),
      .level   (unused_run_level),
      .press   (run_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_step),
      .level   (unused_step_level),
      .press   (step_press)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_RUNNING;
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         state <= state_next;
         presc <= presc_next;
         tick  <= tick_next;
      end
   end

   // A run press outranks both a coincident terminal count and a coincident step press.
   always_comb begin
      state_next = state;
      presc_next = presc;
      tick_next  = 1'b0;
      case (state)
         ST_RUNNING: begin
            if (run_press) begin
               state_next = ST_PAUSED;
               presc_next = '0;
            end else if (presc == PRESC_LAST) begin
               presc_next = '0;
               tick_next  = 1'b1;
            end else begin
               presc_next = presc + 1'b1;
            end
         end
         ST_PAUSED: begin
            presc_next = '0;
            if (run_press) begin
               state_next = ST_RUNNING;
            end else if (step_press) begin
               tick_next = 1'b1;
            end
         end
         default: begin
            state_next = ST_RUNNING;
            presc_next = '0;
         end
      endcase
   end

   assign running = (state == ST_RUNNING);

endmodule

// File: tb/tb_count_tick_ctrl.sv
// Directed bench for count_tick_ctrl with PRESCALE=4 and DEBOUNCE_CYCLES=3;
// cycle indices count rising edges after the stimulus change or reset release.
module tb_count_tick_ctrl;

   logic clk      = 1'b0;
   logic reset    = 1'b0;
   logic btn_run  = 1'b0;
   logic btn_step = 1'b0;
   logic tick;
   logic running;

   int errCount   = 0;
   int checkCount = 0;
   int nTicks     = 0;

   always #5 clk = ~clk;

   count_tick_ctrl #(
      .PRESCALE        (4),
      .DEBOUNCE_CYCLES (3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_run  (btn_run),
      .btn_step (btn_step),
      .tick     (tick),
      .running  (running)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive the buttons just after an edge, then advance to 1 time unit past the next edge.
   task automatic applyStimulus(input logic runLvl, input logic stepLvl);
      btn_run  = runLvl;
      btn_step = stepLvl;
      @(posedge clk);
      #1;
   endtask

   task automatic checkCycle(input string tag, input int i, input int expTick, input int expRun);
      checkOutput($sformatf("%s tick c%0d", tag, i), tick, expTick);
      checkOutput($sformatf("%s running c%0d", tag, i), running, expRun);
   endtask

   initial begin
      $display("[TB] start");
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkCycle("reset", 0, 0, 1);
      reset = 1'b1;

      // Free-running ticks every 4 cycles from reset release.
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(1'b0, 1'b0);
         checkCycle("t1", i, int'(i % 4 == 0), 1);
      end

      // Run held 10 cycles: one tick still due at 4, pause lands at 7, release is silent.
      for (int i = 1; i <= 24; i++) begin
         applyStimulus(i <= 10, 1'b0);
         checkCycle("t2", i, int'(i == 4), int'(i < 7));
      end

      // Three separate step presses while paused.
      for (int p = 0; p < 3; p++) begin
         for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, i <= 6);
            checkCycle($sformatf("t3 p%0d", p), i, int'(i == 7), 0);
            nTicks += int'(tick);
         end
      end
      checkOutput("t3 step tick total", nTicks, 3);

      // Run and step together: resume wins, first prescaled tick 4 cycles after resume.
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(i <= 6, i <= 6);
         checkCycle("t4", i, int'(i == 11 || i == 15), int'(i >= 7));
      end

      // Bouncing run button; pause lands on the would-be tick at 19, which is suppressed.
      for (int i = 1; i <= 32; i++) begin
         applyStimulus((i <= 12) ? (((i - 1) / 2) % 2 == 0) : (i <= 22), 1'b0);
         checkCycle("t5", i, int'(i % 4 == 3 && i < 19), int'(i < 19));
      end

      // Reset while paused and mid-debounce of a run press.
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 1'b0);
         checkCycle("t6a", i, 0, 0);
      end
      reset   = 1'b0;
      btn_run = 1'b0;
      #1;
      checkCycle("t6a in reset", 0, 0, 1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      reset = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(1'b0, 1'b0);
         checkCycle("t6a after", i, int'(i % 4 == 0), 1);
      end

      // Reset mid-prescale: the first tick after release must still take a full period.
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      reset = 1'b0;
      #1;
      checkCycle("t6b in reset", 0, 0, 1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      reset = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(1'b0, 1'b0);
         checkCycle("t6b after", i, int'(i % 4 == 0), 1);
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/count_tick_ctrl.md
# count_tick_ctrl

Rate and step controller sitting directly upstream of the four-bit LED counter. It replaces the practice of clocking the counter from a divider bit with a single-cycle `tick` enable in the `clk` domain. It debounces two board push-buttons, run/pause and single-step, and drives `tick` either periodically (RUNNING) or once per step press (PAUSED).

## Interface
- `PRESCALE`, default 134_217_728: clk cycles per tick in RUNNING, about 1 s at 134 MHz. Must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_340_000: consecutive stable synchronized samples needed to accept a button level change, about 10 ms. Must be ≥ 1.
- `clk` input 1: single system clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset. Assertion takes effect immediately; release is sampled on `clk`.
- `btn_run` input 1: raw, asynchronous run/pause button, active-high.
- `btn_step` input 1: raw, asynchronous single-step button, active-high.
- `tick` output 1: one-cycle count-enable pulse to the downstream counter.
- `running` output 1: 1 in RUNNING and 0 in PAUSED. Drives the status LED.

## Operation
- Reset values:
  - `tick` = 0, `running` = 1, state = RUNNING.
  - Prescaler = 0.
  - Synchronizer flops, debounced levels and debounce counters = 0.
- Input path, per button:
  - Two-flop synchronizer feeds a debouncer.
  - The debounce counter increments while the synchronized value differs from the debounced level. It clears whenever they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A press event is a one-cycle pulse on the debounced level's rising edge. Releases produce no event.
- FSM with two states:
  - RUNNING, on run press: go to PAUSED.
  - PAUSED, on run press: go to RUNNING.
  - Step press in RUNNING: ignored.
  - Step press in PAUSED: exactly one `tick`; state unchanged.
- Prescaler:
  - Width is `$clog2(PRESCALE)`. It counts only in RUNNING.
  - At `PRESCALE-1` it wraps to 0 and `tick` is asserted for one cycle.
  - It is held at 0 in PAUSED, so each RUNNING entry starts a full period.
- Simultaneous events:
  - Run press and step press in the same cycle: the run press wins and the step is dropped.
  - Run press in the cycle the prescaler hits terminal count: the pause wins, the tick is suppressed and the prescaler clears.
- Held buttons produce a single event. A new event requires a debounced release and then a press.
- Reset mid-operation, including mid-debounce: all state returns to the reset values, and any partial debounce count is discarded.

## Timing
- Raw button edge, stable, to press pulse: 2 cycles of synchronizer, then `DEBOUNCE_CYCLES` cycles, then 1 cycle of edge-detect register.
- Press pulse in cycle N:
  - The state or step action is registered at the end of cycle N.
  - `running` changes in cycle N+1.
  - A step `tick` is high in cycle N+1 only.
- RUNNING:
  - First tick comes `PRESCALE` cycles after entry or after reset release.
  - Subsequent ticks are exactly `PRESCALE` cycles apart.
- `tick` is always registered, glitch-free and never high for two consecutive cycles unless `PRESCALE` = 2 is impossible to violate; with `PRESCALE` ≥ 2 it never is.

## Structure
- Shared package/header holds:
  - FSM state encodings `ST_RUNNING` = 1'b1 and `ST_PAUSED` = 1'b0.
  - Board clock constant `CLK_HZ` = 134_000_000, from which the defaults are derived.
- One sub-module, `btn_debounce`, instantiated twice.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `reset`, `btn_raw`, `level`, `press`.
  - It contains the synchronizer, debounce counter and edge detector.
- The top level holds the FSM, the prescaler and the `tick` register.

## Test plan
All scenarios use `PRESCALE`=4 and `DEBOUNCE_CYCLES`=3.
- Reset release with no buttons pressed: `running`=1 and `tick` pulses at cycles 4, 8 and 12 after release, each one cycle wide.
- `btn_run` held high for 10 cycles, then low for 10 cycles:
  - `running` falls 7 cycles after the raw edge (2 sync + 3 debounce + 1 edge + 1 register).
  - No further ticks occur; the release causes no event.
- In PAUSED, three separate `btn_step` presses: exactly three one-cycle `tick` pulses, each 7 cycles after its raw edge. `running` stays 0.
- In PAUSED, `btn_run` and `btn_step` asserted on the same cycle: `running` goes to 1 and no step tick occurs. The next tick comes 4 cycles after `running` rises.
- `btn_run` bouncing, toggled every 2 cycles for 12 cycles and then held high: exactly one pause event, timed from the final stable edge.
- `reset` asserted low mid-debounce and mid-prescale, then released: outputs return immediately to `tick`=0 and `running`=1. The first tick comes 4 cycles after release, and the partial button press produces no event.
